// File: rtl/idct_8x8_serial.sv
// Serial 8x8 inverse DCT: loads 64 coefficients, then computes each pixel
// with one MAC per cycle against a Q10 cosine table and streams it out.
module idct_8x8_serial #(
  parameter int COEF_W      = 16,
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              busy
);

  localparam int PIX_MAX = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_FIN,
    S_OUT
  } state_t;

  state_t state, state_nx;

  logic [5:0] load_cnt;
  logic [5:0] pix_idx;
  logic [5:0] t;

  logic signed [47:0] acc;
  logic signed [COEF_W-1:0] coef_buf [64];

  logic signed [11:0] c1, c2;
  logic signed [23:0] basis;
  logic signed [COEF_W+23:0] term;
  logic signed [47:0] term_x;
  logic signed [47:0] pv;
  logic [PIX_W-1:0] pix_c;

  // cos folded to the first quadrant: (2n+1)k mod 32 indexes pi/16 steps
  function automatic logic signed [11:0] cos_q10(
    input logic [2:0] k,
    input logic [2:0] n
  );
    logic [4:0] m;
    logic [4:0] r;
    logic neg;
    logic signed [11:0] v;
    m   = {1'b0, n, 1'b1} * {2'b0, k};
    neg = 1'b0;
    r   = (m > 5'd16) ? (5'd0 - m) : m;
    if (r > 5'd8) begin
      neg = 1'b1;
      r   = 5'd16 - r;
    end
    case (r)
      5'd0:    v = 12'sd512;
      5'd1:    v = 12'sd502;
      5'd2:    v = 12'sd473;
      5'd3:    v = 12'sd426;
      5'd4:    v = 12'sd362;
      5'd5:    v = 12'sd284;
      5'd6:    v = 12'sd196;
      5'd7:    v = 12'sd100;
      default: v = 12'sd0;
    endcase
    if (k == 3'd0) begin
      v   = 12'sd362;
      neg = 1'b0;
    end
    return neg ? -v : v;
  endfunction

  assign c1     = cos_q10(t[5:3], pix_idx[5:3]);
  assign c2     = cos_q10(t[2:0], pix_idx[2:0]);
  assign basis  = c1 * c2;
  assign term   = coef_buf[t] * basis;
  assign term_x = {{(24-COEF_W){term[COEF_W+23]}}, term};

  // Q20 -> integer with round-half-up, then level shift
  assign pv = ((acc + 48'sd524288) >>> 20) + 48'(LEVEL_SHIFT);

  always_comb begin
    pix_c = pv[PIX_W-1:0];
    if (pv < 48'sd0)
      pix_c = '0;
    else if (pv > 48'(PIX_MAX))
      pix_c = PIX_W'(PIX_MAX);
  end

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_LOAD) || (load_cnt != 6'd0);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:
        if (in_valid && load_cnt == 6'd63)
          state_nx = S_MAC;
      S_MAC:
        if (t == 6'd63)
          state_nx = S_FIN;
      S_FIN:
        state_nx = S_OUT;
      S_OUT:
        if (out_ready)
          state_nx = (pix_idx == 6'd63) ? S_LOAD : S_MAC;
      default:
        state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      load_cnt  <= '0;
      pix_idx   <= '0;
      t         <= '0;
      acc       <= '0;
      out_pixel <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            load_cnt <= load_cnt + 6'd1;
            if (load_cnt == 6'd63) begin
              pix_idx <= '0;
              t       <= '0;
              acc     <= '0;
            end
          end
        end
        S_MAC: begin
          acc <= acc + term_x;
          t   <= t + 6'd1;
        end
        S_FIN: begin
          out_pixel <= pix_c;
        end
        S_OUT: begin
          if (out_ready) begin
            pix_idx <= pix_idx + 6'd1;
            t       <= '0;
            acc     <= '0;
            if (pix_idx == 6'd63)
              load_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // coefficient storage needs no reset; load_cnt governs what is valid
  always_ff @(posedge clk) begin
    if (!rst && state == S_LOAD && in_valid)
      coef_buf[load_cnt] <= in_coef;
  end

endmodule

// File: tb/tb_idct_8x8_serial.sv
// Bench for idct_8x8_serial: random and directed blocks
// checked against a real-arithmetic IDCT reference.
module tb_idct_8x8_serial;

  localparam int COEF_W = 16;
  localparam int PIX_W  = 8;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [COEF_W-1:0] in_coef;
  logic out_valid;
  logic out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic busy;

  int n_chk = 0;
  int n_err = 0;
  bit aborted = 1'b0;

  int ct[8][8];
  int coefs[64];
  int expv[64];
  int got[64];

  idct_8x8_serial #(
    .COEF_W(COEF_W),
    .PIX_W(PIX_W),
    .LEVEL_SHIFT(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_coef(in_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_table();
    real a, v;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        v = 1024.0 * a * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        ct[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
  endtask

  task automatic model();
    longint acc, v;
    for (int p = 0; p < 64; p++) begin
      acc = 0;
      for (int k1 = 0; k1 < 8; k1++)
        for (int k2 = 0; k2 < 8; k2++)
          acc += longint'(coefs[8 * k1 + k2]) *
                 longint'(ct[k1][p / 8]) * longint'(ct[k2][p % 8]);
      v = ((acc + (longint'(1) << 19)) >>> 20) + 128;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      expv[p] = int'(v);
    end
  endtask

  task automatic clear_coefs();
    for (int i = 0; i < 64; i++) coefs[i] = 0;
  endtask

  task automatic run_block(input bit gaps, input bit stalls, input int rst_pix);
    int idx, n, guard;
    bit hs;
    logic [PIX_W-1:0] held;
    if (aborted) return;
    model();
    idx = 0;
    guard = 0;
    while (idx < 64 && guard < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_coef  = COEF_W'(coefs[idx]);
      chk("no_stale_out", out_valid, 0);
      chk("in_ready_load", in_ready, 1);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < 64) begin
      chk("load_timeout", idx, 64);
      aborted = 1'b1;
      return;
    end
    chk("in_ready_drop", in_ready, 0);
    chk("busy_compute", busy, 1);
    for (int p = 0; p < 64; p++) begin
      n = 0;
      while (!out_valid && n < 200) begin
        chk("in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) begin
        chk("out_timeout", 0, 1);
        aborted = 1'b1;
        return;
      end
      chk($sformatf("latency%0d", p), n, 65);
      got[p] = int'(out_pixel);
      chk($sformatf("pix%0d", p), out_pixel, expv[p]);
      if (p == rst_pix) begin
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_pixel", out_pixel, 0);
        return;
      end
      held = out_pixel;
      if (stalls) begin
        while ($urandom_range(0, 2) == 0) begin
          out_ready = 1'b0;
          @(posedge clk); #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_pixel", out_pixel, held);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (p < 63) begin
        chk("valid_drop", out_valid, 0);
      end else begin
        chk("in_ready_back", in_ready, 1);
        chk("busy_idle", busy, 0);
      end
    end
  endtask

  task automatic load_then_reset(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_coef  = COEF_W'(3000 + i);
      @(posedge clk); #1;
    end
    chk("partial_busy", busy, 1);
    rst = 1'b1;
    in_coef = COEF_W'(1234);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("prst_in_ready", in_ready, 1);
    chk("prst_busy", busy, 0);
    chk("prst_out_valid", out_valid, 0);
  endtask

  task automatic expect_all(input string tag, input int v);
    if (aborted) return;
    for (int i = 0; i < 64; i++) chk(tag, got[i], v);
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1;
    in_valid = 1'b0;
    in_coef = '0;
    out_ready = 1'b0;
    build_table();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_pixel", out_pixel, 0);

    clear_coefs(); coefs[0] = 800;
    run_block(0, 0, -1);
    expect_all("dc800", 228);

    clear_coefs(); coefs[0] = 2000;
    run_block(0, 0, -1);
    expect_all("dc2000", 255);

    clear_coefs(); coefs[0] = -1024;
    run_block(0, 0, -1);
    expect_all("dc_neg", 0);

    clear_coefs();
    run_block(0, 0, -1);
    expect_all("zeros", 128);

    clear_coefs(); coefs[1] = 100;
    run_block(0, 0, -1);
    if (!aborted)
      for (int n1 = 0; n1 < 8; n1++) begin
        chk("ac_col0", got[8 * n1], 145);
        chk("ac_col7", got[8 * n1 + 7], 111);
      end

    for (int i = 0; i < 64; i++) coefs[i] = int'($urandom_range(0, 1023)) - 512;
    run_block(1, 1, -1);

    for (int i = 0; i < 64; i++) begin
      r = 16'($urandom);
      coefs[i] = int'($signed(r));
    end
    run_block(1, 1, -1);

    if (!aborted) load_then_reset(30);
    clear_coefs(); coefs[0] = 800;
    run_block(1, 0, -1);
    expect_all("after_prst", 228);

    for (int i = 0; i < 64; i++) coefs[i] = int'($urandom_range(0, 255)) - 128;
    run_block(0, 1, 10);
    clear_coefs(); coefs[0] = 800;
    run_block(0, 1, -1);
    expect_all("after_orst", 228);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
